// File: rtl/capp_pkg.sv
// rtl/capp_pkg.sv - shared types and rail encoders for the CAPP command sequencer
package capp_pkg;

  localparam int CAPP_WORDS = 100;
  localparam int CAPP_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_SEARCH     = 3'd0,
    OP_SEARCH_AND = 3'd1,
    OP_WRITE      = 3'd2,
    OP_READ_FIRST = 3'd3,
    OP_SET_TAGS   = 3'd4,
    OP_CLEAR_TAGS = 3'd5,
    OP_NOP6       = 3'd6,
    OP_NOP7       = 3'd7
  } capp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } capp_state_e;

  // Returns {rail[2j+1], rail[2j]}: [2j] flags a stored 0 when searching for a 1.
  function automatic logic [1:0] search_rail(input logic d, input logic m);
    if (!m) return 2'b00;
    return d ? 2'b01 : 2'b10;
  endfunction

  // Returns {write0, write1} for one bit position.
  function automatic logic [1:0] write_rail(input logic d, input logic m);
    if (!m) return 2'b00;
    return d ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/capp_resolver.sv
// rtl/capp_resolver.sv - lowest-index priority encoder and popcount over the responder vector
module capp_resolver #(
  parameter int WORDS = 100
) (
  input  logic [WORDS-1:0]           i_vec,
  output logic [WORDS-1:0]           o_onehot,
  output logic [$clog2(WORDS)-1:0]   o_index,
  output logic                       o_any,
  output logic [$clog2(WORDS+1)-1:0] o_count
);
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS+1);

  always_comb begin
    o_onehot = '0;
    o_index  = '0;
    o_any    = 1'b0;
    o_count  = '0;
    // Scanning downward lets the lowest set index overwrite any higher one.
    for (int i = WORDS-1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_index     = IW'(i);
        o_any       = 1'b1;
      end
    end
    for (int i = 0; i < WORDS; i++) begin
      o_count = o_count + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/capp_sequencer.sv
// rtl/capp_sequencer.sv - command sequencer driving CAPP array lines and the responder tag register
module capp_sequencer
  import capp_pkg::*;
#(
  parameter int WORDS  = CAPP_WORDS,
  parameter int WIDTH  = CAPP_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  input  logic [WIDTH-1:0]           cmd_mask,
  output logic [2*WIDTH-1:0]         mismatch_lines,
  output logic [2*WIDTH-1:0]         write_lines,
  output logic [WORDS-1:0]           word_sel,
  input  logic [WORDS-1:0]           match_lines,
  input  logic [WIDTH-1:0]           read_lines,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [$clog2(WORDS)-1:0]   rsp_index,
  output logic [$clog2(WORDS+1)-1:0] rsp_count,
  output logic                       rsp_hit
);
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS+1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  capp_state_e      r_state, w_state_nxt;
  capp_op_e         r_op;
  logic [WIDTH-1:0] r_data, r_mask;
  logic [WORDS-1:0] r_tags;
  logic [SW-1:0]    r_settle;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IW-1:0]    r_rsp_index;
  logic [CW-1:0]    r_rsp_count;
  logic             r_rsp_hit;

  logic             w_accept, w_last, w_is_search, w_any;
  logic [WORDS-1:0] w_search_tags, w_res_in, w_onehot;
  logic [IW-1:0]    w_index;
  logic [CW-1:0]    w_count;

  assign w_accept      = (r_state == ST_IDLE) && cmd_valid;
  assign w_last        = (r_settle == SW'(SETTLE-1));
  assign w_is_search   = (r_op == OP_SEARCH) || (r_op == OP_SEARCH_AND);
  assign w_search_tags = (r_op == OP_SEARCH_AND) ? (r_tags & ~match_lines) : ~match_lines;
  // During a search the resolver counts the post-search tags; otherwise it sees the live tags.
  assign w_res_in      = ((r_state == ST_DRIVE) && w_is_search) ? w_search_tags : r_tags;

  capp_resolver #(.WORDS(WORDS)) u_resolver (
    .i_vec    (w_res_in),
    .o_onehot (w_onehot),
    .o_index  (w_index),
    .o_any    (w_any),
    .o_count  (w_count)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_index = r_rsp_index;
  assign rsp_count = r_rsp_count;
  assign rsp_hit   = r_rsp_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (cmd_valid) w_state_nxt = cmd_op[2] ? ST_RESP : ST_DRIVE;
      ST_DRIVE: if (w_last) w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mismatch_lines = '0;
    write_lines    = '0;
    word_sel       = '0;
    if (r_state == ST_DRIVE) begin
      if (w_is_search) begin
        for (int j = 0; j < WIDTH; j++) mismatch_lines[2*j +: 2] = search_rail(r_data[j], r_mask[j]);
      end
      if (r_op == OP_WRITE) begin
        for (int j = 0; j < WIDTH; j++) write_lines[2*j +: 2] = write_rail(r_data[j], r_mask[j]);
        word_sel = r_tags;
      end
      if (r_op == OP_READ_FIRST) word_sel = w_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= OP_NOP6;
      r_data      <= '0;
      r_mask      <= '0;
      r_tags      <= '0;
      r_settle    <= '0;
      r_rsp_data  <= '0;
      r_rsp_index <= '0;
      r_rsp_count <= '0;
      r_rsp_hit   <= 1'b0;
    end else if (w_accept) begin
      r_op     <= capp_op_e'(cmd_op);
      r_data   <= cmd_data;
      r_mask   <= cmd_mask;
      r_settle <= '0;
      if (cmd_op[2]) begin
        r_rsp_data  <= '0;
        r_rsp_index <= '0;
        case (cmd_op)
          3'd4: begin r_tags <= '1; r_rsp_count <= CW'(WORDS); r_rsp_hit <= 1'b1; end
          3'd5: begin r_tags <= '0; r_rsp_count <= '0;         r_rsp_hit <= 1'b0; end
          default: begin r_rsp_count <= w_count; r_rsp_hit <= w_any; end
        endcase
      end
    end else if (r_state == ST_DRIVE) begin
      r_settle <= r_settle + SW'(1);
      if (w_last) begin
        r_rsp_data  <= '0;
        r_rsp_index <= '0;
        r_rsp_count <= w_count;
        r_rsp_hit   <= w_any;
        case (r_op)
          OP_SEARCH, OP_SEARCH_AND: r_tags <= w_search_tags;
          OP_READ_FIRST: if (w_any) begin
            r_tags      <= r_tags & ~w_onehot;
            r_rsp_data  <= read_lines;
            r_rsp_index <= w_index;
            r_rsp_count <= w_count - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capp_sequencer.sv
// tb/tb_capp_sequencer.sv - self-checking bench for capp_sequencer with an array model and reference model
module tb_capp_sequencer;
  localparam int WORDS = 100;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_hit;
  logic [2:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_data, cmd_mask, read_lines, rsp_data;
  logic [2*WIDTH-1:0] mismatch_lines, write_lines;
  logic [WORDS-1:0]   word_sel, match_lines;
  logic [6:0]         rsp_index, rsp_count;

  capp_sequencer #(.WORDS(WORDS), .WIDTH(WIDTH), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .mismatch_lines(mismatch_lines),
    .write_lines(write_lines), .word_sel(word_sel), .match_lines(match_lines),
    .read_lines(read_lines), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_index(rsp_index), .rsp_count(rsp_count), .rsp_hit(rsp_hit)
  );

  // Second build with SETTLE=3 and a small static array.
  logic               c3_valid, c3_ready, c3_rsp_valid, c3_rsp_ready, c3_hit;
  logic [2:0]         c3_op;
  logic [WIDTH-1:0]   c3_data, c3_mask, c3_rsp_data;
  logic [2*WIDTH-1:0] c3_mm, c3_wl;
  logic [7:0]         c3_sel, c3_match;
  logic [2:0]         c3_index;
  logic [3:0]         c3_count;

  capp_sequencer #(.WORDS(8), .WIDTH(WIDTH), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
    .cmd_data(c3_data), .cmd_mask(c3_mask), .mismatch_lines(c3_mm), .write_lines(c3_wl),
    .word_sel(c3_sel), .match_lines(c3_match), .read_lines(32'h0), .rsp_valid(c3_rsp_valid),
    .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data), .rsp_index(c3_index),
    .rsp_count(c3_count), .rsp_hit(c3_hit)
  );

  logic [WIDTH-1:0] arr     [WORDS];
  logic [WIDTH-1:0] ref_mem [WORDS];
  logic [WORDS-1:0] ref_tags;
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] last_data;
  int               last_idx, last_cnt;
  logic             last_hit;

  // Cell array: a word mismatches if any driven rail flags its stored bit value.
  always_comb begin
    match_lines = '0;
    read_lines  = '0;
    for (int i = 0; i < WORDS; i++) begin
      for (int j = 0; j < WIDTH; j++)
        if ((mismatch_lines[2*j] && !arr[i][j]) || (mismatch_lines[2*j+1] && arr[i][j]))
          match_lines[i] = 1'b1;
      if (word_sel[i]) read_lines = read_lines | arr[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (word_sel[i] && (write_lines != '0)) begin
        logic [WIDTH-1:0] w;
        w = arr[i];
        for (int j = 0; j < WIDTH; j++) begin
          if (write_lines[2*j]) w[j] = 1'b1;
          else if (write_lines[2*j+1]) w[j] = 1'b0;
        end
        arr[i] <= w;
      end
    end
  end

  function automatic logic [63:0] exp_rails(input logic [31:0] d, input logic [31:0] m);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 32; j++)
      if (m[j]) begin
        if (d[j]) r[2*j] = 1'b1;
        else      r[2*j+1] = 1'b1;
      end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic [2:0] op, input logic [31:0] d, input logic [31:0] m,
                           output logic [31:0] e_data, output int e_idx, output int e_cnt,
                           output logic e_hit);
    logic [WORDS-1:0] resp;
    logic found;
    e_data = '0; e_idx = 0; found = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        for (int i = 0; i < WORDS; i++) resp[i] = (((ref_mem[i] ^ d) & m) == 32'h0);
        ref_tags = (op == 3'd1) ? (ref_tags & resp) : resp;
      end
      3'd2: for (int i = 0; i < WORDS; i++)
              if (ref_tags[i]) ref_mem[i] = (ref_mem[i] & ~m) | (d & m);
      3'd3: for (int i = 0; i < WORDS; i++)
              if (!found && ref_tags[i]) begin
                found = 1'b1; e_data = ref_mem[i]; e_idx = i; ref_tags[i] = 1'b0;
              end
      3'd4: ref_tags = '1;
      3'd5: ref_tags = '0;
      default: ;
    endcase
    e_cnt = $countones(ref_tags);
    e_hit = (op == 3'd3) ? found : (e_cnt != 0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] d,
                       input logic [31:0] m, input int hold);
    logic [31:0] e_data; int e_idx, e_cnt; logic e_hit;
    logic [63:0] drv_mm, drv_wl; logic [WORDS-1:0] drv_ws, pre_tags;
    logic [31:0] s_data; logic [6:0] s_idx, s_cnt; logic s_hit;
    int lat;
    pre_tags = ref_tags;
    ref_model(op, d, m, e_data, e_idx, e_cnt, e_hit);
    check({tag, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = $urandom; cmd_mask = $urandom;
    lat = 0; drv_mm = '0; drv_wl = '0; drv_ws = '0;
    while (!rsp_valid && lat < 20) begin
      drv_mm |= mismatch_lines; drv_wl |= write_lines; drv_ws |= word_sel;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), op[2] ? 64'd0 : 64'd1);
    check({tag, "/count"}, 64'(rsp_count), 64'(e_cnt));
    check({tag, "/hit"}, 64'(rsp_hit), 64'(e_hit));
    check({tag, "/lines_idle"}, 64'(|{mismatch_lines, write_lines, word_sel}), 64'd0);
    if (op == 3'd3) begin
      check({tag, "/data"}, 64'(rsp_data), 64'(e_data));
      check({tag, "/index"}, 64'(rsp_index), 64'(e_idx));
    end
    if (op == 3'd0 || op == 3'd1) check({tag, "/mismatch"}, drv_mm, exp_rails(d, m));
    if (op == 3'd2) begin
      check({tag, "/write"}, drv_wl, exp_rails(d, m));
      check({tag, "/wsel"}, 64'(drv_ws == pre_tags), 64'd1);
    end
    s_data = rsp_data; s_idx = rsp_index; s_cnt = rsp_count; s_hit = rsp_hit;
    for (int k = 0; k < hold; k++) begin
      if (k == 1) begin cmd_valid = 1'b1; cmd_op = 3'd4; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check({tag, "/stall"}, 64'({rsp_valid, cmd_ready}), 64'b10);
      check({tag, "/stable"}, 64'({s_data, s_idx, s_cnt, s_hit} == {rsp_data, rsp_index, rsp_count, rsp_hit}), 64'd1);
    end
    last_data = rsp_data; last_idx = rsp_index; last_cnt = rsp_count; last_hit = rsp_hit;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "/done"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    if (hold > 0) begin
      @(posedge clk); #1;
      check({tag, "/no_ghost"}, 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] d, m;
    int lat3;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mask = '0;
    c3_valid = 1'b0; c3_rsp_ready = 1'b0; c3_op = '0; c3_data = '0; c3_mask = '0; c3_match = 8'hB2;
    for (int i = 0; i < WORDS; i++) begin
      ref_mem[i] = 32'hA500_0000 | i;
    end
    ref_mem[0] = 32'd456; ref_mem[1] = 32'd457; ref_mem[5] = 32'd457; ref_mem[4] = 32'd1000;
    for (int i = 0; i < WORDS; i++) arr[i] <= ref_mem[i];
    ref_tags = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset/ready_valid", 64'({cmd_ready, rsp_valid}), 64'b10);
    check("reset/lines", 64'(|{mismatch_lines, write_lines, word_sel}), 64'd0);
    check("reset/rsp", 64'({rsp_data, rsp_index, rsp_count, rsp_hit}), 64'd0);

    do_op("search457", 3'd0, 32'd457, 32'hFFFF_FFFF, 0);
    check("search457/plan_cnt", 64'(last_cnt), 64'd2);
    do_op("rf1", 3'd3, 0, 0, 0);
    check("rf1/plan", 64'({last_data, 8'(last_idx)}), {24'h0, 32'd457, 8'd1});
    do_op("rf2", 3'd3, 0, 0, 0);
    check("rf2/plan", 64'({last_data, 8'(last_idx)}), {24'h0, 32'd457, 8'd5});
    do_op("rf3", 3'd3, 0, 0, 0);
    check("rf3/plan", 64'({last_data, last_hit}), 64'd0);
    do_op("search456", 3'd0, 32'd456, 32'hFFFF_FFFE, 0);
    check("search456/plan_cnt", 64'(last_cnt), 64'd3);
    do_op("search_and", 3'd1, 32'd1, 32'd1, 0);
    check("search_and/plan_cnt", 64'(last_cnt), 64'd2);
    do_op("write0", 3'd2, 32'd0, 32'h0000_FFFF, 0);
    do_op("rf_w1", 3'd3, 0, 0, 0);
    check("rf_w1/plan", 64'({last_data, 8'(last_idx)}), {24'h0, 32'd0, 8'd1});
    do_op("rf_w5", 3'd3, 0, 0, 0);
    check("rf_w5/plan", 64'({last_data, 8'(last_idx)}), {24'h0, 32'd0, 8'd5});

    do_op("stall", 3'd0, 32'd0, 32'h0000_FFFF, 5);
    check("stall/plan_cnt", 64'(last_cnt), 64'd2);

    do_op("search1000", 3'd0, 32'd1000, 32'hFFFF_FFFF, 0);
    cmd_op = 3'd2; cmd_data = 32'd1000; cmd_mask = 32'hFFFF_FFFF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rst_mid/drive_lines", 64'((write_lines != '0) && (word_sel != '0)), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid/lines", 64'(|{mismatch_lines, write_lines, word_sel}), 64'd0);
    check("rst_mid/state", 64'({rsp_valid, cmd_ready}), 64'b01);
    rst_n = 1'b1;
    ref_tags = '0;
    do_op("rst_mid/nop", 3'd6, 0, 0, 0);
    check("rst_mid/tags", 64'(last_cnt), 64'd0);
    do_op("clear", 3'd5, 0, 0, 0);
    check("clear/plan_cnt", 64'(last_cnt), 64'd0);
    do_op("set", 3'd4, 0, 0, 0);
    check("set/plan_cnt", 64'(last_cnt), 64'(WORDS));

    for (int n = 0; n < 40; n++) begin
      d = ref_mem[$urandom_range(0, WORDS-1)];
      if ($urandom_range(0, 2) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: m = 32'hFFFF_FFFF;
        1: m = 32'h0000_FFFF;
        default: m = $urandom;
      endcase
      do_op($sformatf("rand%0d", n), 3'($urandom_range(0, 7)), d, m, $urandom_range(0, 2));
    end

    d = $urandom;
    c3_op = 3'd0; c3_data = d; c3_mask = 32'hFFFF_FFFF; c3_valid = 1'b1;
    @(posedge clk); #1;
    c3_valid = 1'b0; c3_data = ~d;
    lat3 = 1;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("settle3/drive%0d", k), 64'({c3_rsp_valid, c3_ready, c3_mm == exp_rails(d, 32'hFFFF_FFFF)}), 64'b001);
      @(posedge clk); #1;
      lat3++;
    end
    check("settle3/latency", 64'({c3_rsp_valid, 8'(lat3)}), {55'd0, 1'b1, 8'd4});
    check("settle3/count", 64'({c3_count, c3_hit}), {59'd0, 4'd4, 1'b1});
    check("settle3/lines_resp", 64'(|{c3_mm, c3_wl, c3_sel}), 64'd0);
    c3_rsp_ready = 1'b1;
    @(posedge clk); #1;
    c3_rsp_ready = 1'b0;
    check("settle3/done", 64'({c3_rsp_valid, c3_ready}), 64'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
